// File: rtl/cls_pkg.sv
// Shared types for the lockstep supervisor: fault causes, supervisor states
// and the mapping from a compared field to its fault cause.
package cls_pkg;

    typedef enum logic [2:0] {
        NONE       = 3'd0,
        DATA_REQ   = 3'd1,
        DATA_ADDR  = 3'd2,
        DATA_WE    = 3'd3,
        DATA_BE    = 3'd4,
        DATA_WDATA = 3'd5,
        INSTR_REQ  = 3'd6,
        INSTR_ADDR = 3'd7
    } fault_cause_e;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        RST_HOLD = 2'd1,
        HALT     = 2'd2
    } sup_state_e;

    // Compared fields, indexed in fault priority order (0 = highest).
    localparam int NUM_FIELDS = 7;

    function automatic fault_cause_e field_cause(input int idx);
        return fault_cause_e'(3'(idx + 1));
    endfunction

endpackage

// File: rtl/cls_vote_cmp.sv
// Combinational signature builder and majority voter for NCORES lockstep cores.
// Fields that are not qualified by their request/write strobe are masked to zero.
module cls_vote_cmp
    import cls_pkg::*;
#(
    parameter int NCORES = 3,
    parameter int AW     = 32,
    parameter int DW     = 32
) (
    input  logic [NCORES-1:0]        i_instr_req,
    input  logic [NCORES*AW-1:0]     i_instr_addr,
    input  logic [NCORES-1:0]        i_data_req,
    input  logic [NCORES-1:0]        i_data_we,
    input  logic [NCORES*DW/8-1:0]   i_data_be,
    input  logic [NCORES*AW-1:0]     i_data_addr,
    input  logic [NCORES*DW-1:0]     i_data_wdata,
    output logic                     o_mismatch,
    output fault_cause_e             o_cause,
    output logic [NCORES-1:0]        o_fault_core
);

    localparam int BW = DW / 8;
    localparam int SW = 3 + 2 * AW + BW + DW;

    logic          w_dreq  [NCORES];
    logic [AW-1:0] w_daddr [NCORES];
    logic          w_we    [NCORES];
    logic [BW-1:0] w_be    [NCORES];
    logic [DW-1:0] w_wdata [NCORES];
    logic          w_ireq  [NCORES];
    logic [AW-1:0] w_iaddr [NCORES];
    logic [SW-1:0] w_sig   [NCORES];
    logic [NUM_FIELDS-1:0] w_diff;

    for (genvar g = 0; g < NCORES; g++) begin : g_sig
        assign w_dreq[g]  = i_data_req[g];
        assign w_daddr[g] = i_data_req[g] ? i_data_addr[g*AW +: AW] : '0;
        assign w_we[g]    = i_data_req[g] & i_data_we[g];
        assign w_be[g]    = w_we[g] ? i_data_be[g*BW +: BW] : '0;
        assign w_wdata[g] = w_we[g] ? i_data_wdata[g*DW +: DW] : '0;
        assign w_ireq[g]  = i_instr_req[g];
        assign w_iaddr[g] = i_instr_req[g] ? i_instr_addr[g*AW +: AW] : '0;
        assign w_sig[g]   = {w_dreq[g], w_daddr[g], w_we[g], w_be[g],
                             w_wdata[g], w_ireq[g], w_iaddr[g]};
    end

    // Per-field divergence of any core against core 0.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
        w_diff = '0;
        for (int i = 1; i < NCORES; i++) begin
            if (w_dreq[i]  != w_dreq[0])  w_diff[0] = 1'b1;
            if (w_daddr[i] != w_daddr[0]) w_diff[1] = 1'b1;
            if (w_we[i]    != w_we[0])    w_diff[2] = 1'b1;
            if (w_be[i]    != w_be[0])    w_diff[3] = 1'b1;
            if (w_wdata[i] != w_wdata[0]) w_diff[4] = 1'b1;
            if (w_ireq[i]  != w_ireq[0])  w_diff[5] = 1'b1;
            if (w_iaddr[i] != w_iaddr[0]) w_diff[6] = 1'b1;
        end
    end

    assign o_mismatch = |w_diff;

    // Scan from lowest priority upward so the highest-priority hit is left last.
    always_comb begin
        o_cause = NONE;
        for (int k = NUM_FIELDS - 1; k >= 0; k--) begin
            if (w_diff[k]) o_cause = field_cause(k);
        end
    end

    // A core is outvoted unless a strict majority shares its signature; with no
    // majority at all every core ends up flagged.
    for (genvar g = 0; g < NCORES; g++) begin : g_vote
        logic [NCORES-1:0] w_eq;
        always_comb begin
            w_eq = '0;
            for (int h = 0; h < NCORES; h++) begin
                w_eq[h] = (w_sig[h] == w_sig[g]);
            end
        end
        assign o_fault_core[g] = ($countones(w_eq) < (NCORES / 2 + 1));
    end

endmodule

// File: rtl/cls_lockstep_supervisor.sv
// N-core lockstep supervisor: compares core bus requests, pulses the shared core
// reset on divergence, and halts the cluster once the retry budget is spent.
module cls_lockstep_supervisor
    import cls_pkg::*;
#(
    parameter int NCORES       = 3,
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int RST_CYCLES   = 2,
    parameter int CLEAN_WINDOW = 1024,
    parameter int MAX_RETRIES  = 3,
    parameter int CNT_W        = 8,
    localparam int RCW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   clr_cnt,
    input  logic [NCORES-1:0]      instr_req,
    input  logic [NCORES*AW-1:0]   instr_addr,
    input  logic [NCORES-1:0]      data_req,
    input  logic [NCORES-1:0]      data_we,
    input  logic [NCORES*DW/8-1:0] data_be,
    input  logic [NCORES*AW-1:0]   data_addr,
    input  logic [NCORES*DW-1:0]   data_wdata,
    output logic                   core_rst_n,
    output logic                   fault_o,
    output fault_cause_e           fault_cause,
    output logic [NCORES-1:0]      fault_core,
    output logic                   halted,
    output logic [RCW-1:0]         retry_cnt,
    output logic [CNT_W-1:0]       fault_cnt
);

    localparam int HCW = $clog2(RST_CYCLES + 1);
    localparam int CWW = $clog2(CLEAN_WINDOW + 1);

    sup_state_e        r_state;
    logic [HCW-1:0]    r_hold;
    logic              r_blank;
    logic [CWW-1:0]    r_clean;

    logic              w_raw_mismatch;
    fault_cause_e      w_cause;
    logic [NCORES-1:0] w_fault_core;
    logic              w_mismatch;
    logic              w_window_done;
    logic              w_cnt_sat;

    cls_vote_cmp #(
        .NCORES (NCORES),
        .AW     (AW),
        .DW     (DW)
    ) u_vote_cmp (
        .i_instr_req  (instr_req),
        .i_instr_addr (instr_addr),
        .i_data_req   (data_req),
        .i_data_we    (data_we),
        .i_data_be    (data_be),
        .i_data_addr  (data_addr),
        .i_data_wdata (data_wdata),
        .o_mismatch   (w_raw_mismatch),
        .o_cause      (w_cause),
        .o_fault_core (w_fault_core)
    );

    // The first RUN cycle after a core reset is blanked while the cores settle.
    assign w_mismatch    = enable & (r_state == RUN) & ~r_blank & w_raw_mismatch;
    assign w_window_done = (r_clean == CWW'(CLEAN_WINDOW - 1));
    assign w_cnt_sat     = &fault_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= RST_HOLD;
            r_hold      <= HCW'(RST_CYCLES);
            r_blank     <= 1'b0;
            r_clean     <= '0;
            core_rst_n  <= 1'b0;
            fault_o     <= 1'b0;
            fault_cause <= NONE;
            fault_core  <= '0;
            halted      <= 1'b0;
            retry_cnt   <= '0;
            fault_cnt   <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every register sees pre-edge values, independent of statement order.
            fault_o <= w_mismatch;
            r_blank <= 1'b0;
            if (w_mismatch) begin
                fault_cause <= w_cause;
                fault_core  <= w_fault_core;
            end

            case (r_state)
                RST_HOLD: begin
                    core_rst_n <= 1'b0;
                    if (r_hold <= HCW'(1)) begin
                        r_state    <= RUN;
                        core_rst_n <= 1'b1;
                        r_blank    <= 1'b1;
                    end else begin
                        r_hold <= r_hold - 1'b1;
                    end
                end
                RUN: begin
                    if (w_mismatch) begin
                        // A fault on the window boundary wins and is judged on the old retry count.
                        r_clean    <= '0;
                        core_rst_n <= 1'b0;
                        if (retry_cnt < RCW'(MAX_RETRIES)) begin
                            retry_cnt <= retry_cnt + 1'b1;
                            r_state   <= RST_HOLD;
                            r_hold    <= HCW'(RST_CYCLES);
                        end else begin
                            r_state <= HALT;
                            halted  <= 1'b1;
                        end
                    end else if (w_window_done) begin
                        r_clean   <= '0;
                        retry_cnt <= '0;
                    end else begin
                        r_clean <= r_clean + 1'b1;
                    end
                end
                HALT: begin
                    core_rst_n <= 1'b0;
                    halted     <= 1'b1;
                end
                default: begin
                    r_state    <= RST_HOLD;
                    r_hold     <= HCW'(RST_CYCLES);
                    core_rst_n <= 1'b0;
                end
            endcase

            if (clr_cnt) begin
                fault_cnt <= w_mismatch ? CNT_W'(1) : '0;
            end else if (w_mismatch && !w_cnt_sat) begin
                fault_cnt <= fault_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cls_lockstep_supervisor.sv
// Self-checking bench: a 3-core instance driven from a table of single-cycle
// divergence vectors plus sequences for hold, blanking, retry, halt and windows;
// a 4-core instance covers the no-majority vote, enable masking and saturation.
module tb_cls_lockstep_supervisor;
    import cls_pkg::*;

    localparam logic [31:0] BASE_IADDR = 32'h0000_1000;
    localparam logic [31:0] BASE_DADDR = 32'h2000_0040;
    localparam logic [31:0] BASE_WDATA = 32'hDEAD_BEEF;
    localparam logic [3:0]  BASE_BE    = 4'hF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic enable, clr_cnt;
    logic [2:0]   instr_req, data_req, data_we;
    logic [95:0]  instr_addr, data_addr, data_wdata;
    logic [11:0]  data_be;
    logic         core_rst_n, fault_o, halted;
    fault_cause_e fault_cause;
    logic [2:0]   fault_core;
    logic [1:0]   retry_cnt;
    logic [7:0]   fault_cnt;

    logic q_enable, q_clr;
    logic [3:0]   q_instr_req, q_data_req, q_data_we;
    logic [127:0] q_instr_addr, q_data_addr, q_data_wdata;
    logic [15:0]  q_data_be;
    logic         q_core_rst_n, q_fault_o, q_halted;
    fault_cause_e q_fault_cause;
    logic [3:0]   q_fault_core;
    logic [2:0]   q_retry_cnt;
    logic [1:0]   q_fault_cnt;

    cls_lockstep_supervisor #(
        .NCORES(3), .AW(32), .DW(32), .RST_CYCLES(2),
        .CLEAN_WINDOW(1024), .MAX_RETRIES(3), .CNT_W(8)
    ) dut3 (
        .clk(clk), .rst(rst), .enable(enable), .clr_cnt(clr_cnt),
        .instr_req(instr_req), .instr_addr(instr_addr),
        .data_req(data_req), .data_we(data_we), .data_be(data_be),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .core_rst_n(core_rst_n), .fault_o(fault_o), .fault_cause(fault_cause),
        .fault_core(fault_core), .halted(halted), .retry_cnt(retry_cnt),
        .fault_cnt(fault_cnt)
    );

    cls_lockstep_supervisor #(
        .NCORES(4), .AW(32), .DW(32), .RST_CYCLES(2),
        .CLEAN_WINDOW(1024), .MAX_RETRIES(7), .CNT_W(2)
    ) dut4 (
        .clk(clk), .rst(rst), .enable(q_enable), .clr_cnt(q_clr),
        .instr_req(q_instr_req), .instr_addr(q_instr_addr),
        .data_req(q_data_req), .data_we(q_data_we), .data_be(q_data_be),
        .data_addr(q_data_addr), .data_wdata(q_data_wdata),
        .core_rst_n(q_core_rst_n), .fault_o(q_fault_o), .fault_cause(q_fault_cause),
        .fault_core(q_fault_core), .halted(q_halted), .retry_cnt(q_retry_cnt),
        .fault_cnt(q_fault_cnt)
    );

    typedef struct packed {
        logic [2:0]  mask;
        logic        f_dreq;
        logic        f_we;
        logic        f_ireq;
        logic [31:0] x_daddr;
        logic [31:0] x_wdata;
        logic [3:0]  x_be;
        logic [31:0] x_iaddr;
    } pert_t;

    typedef struct {
        string        name;
        logic         dreq;
        logic         we;
        logic         ireq;
        pert_t        a;
        pert_t        b;
        logic         e_fault;
        fault_cause_e e_cause;
        logic [2:0]   e_core;
    } vec_t;

    int errors = 0;
    int checks = 0;
    vec_t vecs[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic pert_t mkp(input logic [2:0] m, input logic fd, input logic fw,
                                  input logic fi, input logic [31:0] xa, input logic [31:0] xw,
                                  input logic [3:0] xb, input logic [31:0] xi);
        pert_t p;
        p.mask = m; p.f_dreq = fd; p.f_we = fw; p.f_ireq = fi;
        p.x_daddr = xa; p.x_wdata = xw; p.x_be = xb; p.x_iaddr = xi;
        return p;
    endfunction

    function automatic vec_t mkv(input string n, input logic dr, input logic w, input logic ir,
                                 input pert_t pa, input pert_t pb, input logic ef,
                                 input fault_cause_e ec, input logic [2:0] eco);
        vec_t v;
        v.name = n; v.dreq = dr; v.we = w; v.ireq = ir; v.a = pa; v.b = pb;
        v.e_fault = ef; v.e_cause = ec; v.e_core = eco;
        return v;
    endfunction

    task automatic drive3(input vec_t v);
        logic pa, pb;
        for (int i = 0; i < 3; i++) begin
            pa = v.a.mask[i];
            pb = v.b.mask[i];
            data_req[i]  = v.dreq ^ (pa & v.a.f_dreq) ^ (pb & v.b.f_dreq);
            data_we[i]   = v.we   ^ (pa & v.a.f_we)   ^ (pb & v.b.f_we);
            instr_req[i] = v.ireq ^ (pa & v.a.f_ireq) ^ (pb & v.b.f_ireq);
            data_addr[i*32 +: 32]  = BASE_DADDR ^ (pa ? v.a.x_daddr : 32'h0) ^ (pb ? v.b.x_daddr : 32'h0);
            data_wdata[i*32 +: 32] = BASE_WDATA ^ (pa ? v.a.x_wdata : 32'h0) ^ (pb ? v.b.x_wdata : 32'h0);
            instr_addr[i*32 +: 32] = BASE_IADDR ^ (pa ? v.a.x_iaddr : 32'h0) ^ (pb ? v.b.x_iaddr : 32'h0);
            data_be[i*4 +: 4]      = BASE_BE    ^ (pa ? v.a.x_be    : 4'h0)  ^ (pb ? v.b.x_be    : 4'h0);
        end
    endtask

    task automatic idle3();
        drive3(vecs[0]);
    endtask

    // 4-core traffic: cores 2 and 3 get instr_addr XORed with split.
    task automatic drive4(input logic [31:0] split);
        for (int i = 0; i < 4; i++) begin
            q_instr_req[i] = 1'b1;
            q_data_req[i]  = 1'b1;
            q_data_we[i]   = 1'b1;
            q_data_be[i*4 +: 4]      = BASE_BE;
            q_data_addr[i*32 +: 32]  = BASE_DADDR;
            q_data_wdata[i*32 +: 32] = BASE_WDATA;
            q_instr_addr[i*32 +: 32] = BASE_IADDR ^ ((i >= 2) ? split : 32'h0);
        end
    endtask

    // Random traffic, identical on every core.
    task automatic drive_same_rand();
        logic [31:0] ia, da, wd;
        logic [3:0]  be;
        logic        ir, dr, w;
        ia = $urandom; da = $urandom; wd = $urandom; be = 4'($urandom);
        ir = 1'($urandom); dr = 1'($urandom); w = 1'($urandom);
        for (int i = 0; i < 3; i++) begin
            instr_req[i] = ir; data_req[i] = dr; data_we[i] = w;
            instr_addr[i*32 +: 32] = ia; data_addr[i*32 +: 32] = da;
            data_wdata[i*32 +: 32] = wd; data_be[i*4 +: 4] = be;
        end
    endtask

    // Wait until both instances release core reset; bounded.
    task automatic wait_up();
        int n;
        n = 0;
        while (!(core_rst_n === 1'b1 && q_core_rst_n === 1'b1) && n < 16) begin
            @(negedge clk);
            n++;
        end
        if (!(core_rst_n === 1'b1 && q_core_rst_n === 1'b1)) begin
            checks++;
            errors++;
            $display("FAIL wait_up: core_rst_n=%b q_core_rst_n=%b after %0d cycles", core_rst_n, q_core_rst_n, n);
        end
    endtask

    // Reset, release, wait out the hold and the blanked cycle; next drive is compared.
    task automatic start();
        rst = 1'b1;
        enable = 1'b1; clr_cnt = 1'b0; q_enable = 1'b1; q_clr = 1'b0;
        idle3();
        drive4(32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        wait_up();
        @(negedge clk);
    endtask

    task automatic recover();
        idle3();
        drive4(32'h0);
        wait_up();
        @(negedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        logic [1:0] exp_retry;

        // Table: name, dreq, we, ireq, pert a, pert b, fault, cause, fault_core
        vecs[0]  = mkv("same",        1, 1, 1, mkp(0,0,0,0,0,0,0,0), mkp(0,0,0,0,0,0,0,0), 0, NONE,       3'b000);
        vecs[1]  = mkv("wdata_c2",    1, 1, 1, mkp(3'b100,0,0,0,0,32'h1,0,0), mkp(0,0,0,0,0,0,0,0), 1, DATA_WDATA, 3'b100);
        vecs[2]  = mkv("dreq_c1",     1, 1, 1, mkp(3'b010,1,0,0,32'h10,0,0,32'h4), mkp(0,0,0,0,0,0,0,0), 1, DATA_REQ, 3'b010);
        vecs[3]  = mkv("daddr_c0",    1, 1, 1, mkp(3'b001,0,0,0,32'h4,0,0,0), mkp(0,0,0,0,0,0,0,0), 1, DATA_ADDR, 3'b001);
        vecs[4]  = mkv("we_c1",       1, 1, 1, mkp(3'b010,0,1,0,0,0,0,0), mkp(0,0,0,0,0,0,0,0), 1, DATA_WE, 3'b010);
        vecs[5]  = mkv("be_c2",       1, 1, 1, mkp(3'b100,0,0,0,0,0,4'h1,0), mkp(0,0,0,0,0,0,0,0), 1, DATA_BE, 3'b100);
        vecs[6]  = mkv("wdata_read",  1, 0, 1, mkp(3'b100,0,0,0,0,32'h1,4'h1,0), mkp(0,0,0,0,0,0,0,0), 0, NONE, 3'b000);
        vecs[7]  = mkv("daddr_noreq", 0, 1, 1, mkp(3'b010,0,0,0,32'h100,32'h1,0,0), mkp(0,0,0,0,0,0,0,0), 0, NONE, 3'b000);
        vecs[8]  = mkv("ireq_c0",     1, 1, 1, mkp(3'b001,0,0,1,0,0,0,0), mkp(0,0,0,0,0,0,0,0), 1, INSTR_REQ, 3'b001);
        vecs[9]  = mkv("iaddr_c2",    1, 1, 1, mkp(3'b100,0,0,0,0,0,0,32'h8), mkp(0,0,0,0,0,0,0,0), 1, INSTR_ADDR, 3'b100);
        vecs[10] = mkv("iaddr_3way",  1, 1, 1, mkp(3'b010,0,0,0,0,0,0,32'h4), mkp(3'b100,0,0,0,0,0,0,32'h8), 1, INSTR_ADDR, 3'b111);
        vecs[11] = mkv("be_wd_3way",  1, 1, 1, mkp(3'b010,0,0,0,0,32'h1,0,0), mkp(3'b100,0,0,0,0,0,4'h2,0), 1, DATA_BE, 3'b111);
        vecs[12] = mkv("iaddr_noireq",1, 1, 0, mkp(3'b100,0,0,0,0,0,0,32'h8), mkp(0,0,0,0,0,0,0,0), 0, NONE, 3'b000);

        // Reset values.
        rst = 1'b1;
        enable = 1'b1; clr_cnt = 1'b0; q_enable = 1'b1; q_clr = 1'b0;
        idle3();
        drive4(32'h0);
        @(negedge clk);
        check("rst_core_rst_n", core_rst_n, 0);
        check("rst_fault_o",    fault_o, 0);
        check("rst_cause",      fault_cause, NONE);
        check("rst_core",       fault_core, 0);
        check("rst_halted",     halted, 0);
        check("rst_retry",      retry_cnt, 0);
        check("rst_fault_cnt",  fault_cnt, 0);

        // Initial hold is exactly two cycles, then the first RUN cycle is blanked.
        rst = 1'b0;
        @(negedge clk);
        check("hold_c1", core_rst_n, 0);
        @(negedge clk);
        check("hold_c2", core_rst_n, 1);
        drive3(vecs[1]);
        @(negedge clk);
        check("blank_no_fault", fault_o, 0);
        @(negedge clk);
        check("after_blank_fault", fault_o, 1);
        check("after_blank_cause", fault_cause, DATA_WDATA);
        // enable dropping during the recovery hold leaves the pulse length intact
        enable = 1'b0;
        idle3();
        @(negedge clk);
        check("rec_hold_c1", core_rst_n, 0);
        @(negedge clk);
        check("rec_hold_c2", core_rst_n, 1);
        enable = 1'b1;

        // Table-driven single-cycle divergence vectors, each from a fresh reset.
        for (int k = 0; k < 13; k++) begin
            start();
            drive3(vecs[k]);
            @(negedge clk);
            check({vecs[k].name, "_fault_o"},    fault_o, vecs[k].e_fault);
            check({vecs[k].name, "_cause"},      fault_cause, vecs[k].e_cause);
            check({vecs[k].name, "_core"},       fault_core, vecs[k].e_core);
            check({vecs[k].name, "_retry"},      retry_cnt, vecs[k].e_fault ? 1 : 0);
            check({vecs[k].name, "_fault_cnt"},  fault_cnt, vecs[k].e_fault ? 1 : 0);
            check({vecs[k].name, "_core_rst_n"}, core_rst_n, vecs[k].e_fault ? 0 : 1);
            idle3();
            @(negedge clk);
            check({vecs[k].name, "_pulse_end"},  fault_o, 0);
            check({vecs[k].name, "_cause_held"}, fault_cause, vecs[k].e_cause);
        end

        // Fault on the very cycle the clean window completes: the fault wins.
        start();
        drive3(vecs[1]);
        @(negedge clk);
        check("win_first_retry", retry_cnt, 1);
        idle3();
        repeat (1025) @(negedge clk);
        check("win_pre_retry", retry_cnt, 1);
        drive3(vecs[1]);
        @(negedge clk);
        check("win_tie_fault", fault_o, 1);
        check("win_tie_retry", retry_cnt, 2);

        // Four quick faults exhaust the budget; HALT ignores further mismatches.
        start();
        for (int k = 1; k <= 4; k++) begin
            drive3(vecs[9]);
            @(negedge clk);
            exp_retry = (k <= 3) ? 2'(k) : 2'd3;
            check($sformatf("halt_f%0d_fault", k),  fault_o, 1);
            check($sformatf("halt_f%0d_retry", k),  retry_cnt, exp_retry);
            check($sformatf("halt_f%0d_halted", k), halted, (k == 4) ? 1 : 0);
            if (k < 4) recover();
        end
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (fault_o !== 1'b0 || core_rst_n !== 1'b0 || halted !== 1'b1) bad++;
        end
        check("halt_stuck", bad, 0);
        check("halt_fault_cnt", fault_cnt, 4);
        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
        check("halt_clr", fault_cnt, 0);
        // Asynchronous reset, checked before any clock edge.
        #1 rst = 1'b1;
        #1;
        check("async_halted",     halted, 0);
        check("async_core_rst_n", core_rst_n, 0);
        check("async_retry",      retry_cnt, 0);
        check("async_cause",      fault_cause, NONE);
        check("async_core",       fault_core, 0);

        // clr_cnt with and without a coincident fault.
        start();
        drive3(vecs[1]);
        @(negedge clk);
        check("clr_pre_cnt", fault_cnt, 1);
        recover();
        clr_cnt = 1'b1;
        drive3(vecs[1]);
        @(negedge clk);
        check("clr_tie_cnt", fault_cnt, 1);
        clr_cnt = 1'b0;
        recover();
        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
        check("clr_only_cnt", fault_cnt, 0);

        // 5000 cycles of identical traffic.
        start();
        bad = 0;
        repeat (5000) begin
            drive_same_rand();
            @(negedge clk);
            if (fault_o !== 1'b0 || core_rst_n !== 1'b1) bad++;
        end
        check("clean_run_bad", bad, 0);
        check("clean_run_retry", retry_cnt, 0);
        check("clean_run_cnt", fault_cnt, 0);

        // Faults 1100 cycles apart: the clean window refills the budget each time.
        start();
        for (int k = 0; k < 5; k++) begin
            check($sformatf("spaced_%0d_pre_retry", k), retry_cnt, 0);
            drive3(vecs[1]);
            @(negedge clk);
            check($sformatf("spaced_%0d_retry", k), retry_cnt, 1);
            idle3();
            repeat (1100) @(negedge clk);
        end
        check("spaced_halted", halted, 0);
        check("spaced_fault_cnt", fault_cnt, 5);

        // Four cores, 2-vs-2 split on instr_addr; masked first by enable=0.
        start();
        q_enable = 1'b0;
        drive4(32'h40);
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (q_fault_o !== 1'b0 || q_core_rst_n !== 1'b1) bad++;
        end
        check("n4_enable_mask", bad, 0);
        check("n4_enable_mask_cnt", q_fault_cnt, 0);
        q_enable = 1'b1;
        @(negedge clk);
        check("n4_fault", q_fault_o, 1);
        check("n4_cause", q_fault_cause, INSTR_ADDR);
        check("n4_core",  q_fault_core, 4'b1111);
        for (int k = 0; k < 3; k++) begin
            recover();
            drive4(32'h40);
            @(negedge clk);
        end
        check("n4_sat_cnt", q_fault_cnt, 3);
        check("n4_retry", q_retry_cnt, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cls_lockstep_supervisor.md
# cls_lockstep_supervisor

Parametrised N-core lockstep supervisor: compares the instruction and data bus requests of NCORES redundant cores every cycle. On divergence it flags the fault, identifies the outvoted core(s) by majority and pulses the shared core reset. It bounds repeated recoveries with a retry budget that is refilled after a clean run window, and halts the cluster once the budget is exhausted. It sits between the lockstep cores and the memory interconnect, replacing the fixed 3-core comparator and reset handler pair.

## Interface
- NCORES, 3, number of lockstep cores (2..8)
- AW, 32, address width
- DW, 32, data width (multiple of 8)
- RST_CYCLES, 2, core reset pulse length in cycles (>=1)
- CLEAN_WINDOW, 1024, fault-free RUN cycles that clear the retry count
- MAX_RETRIES, 3, recoveries allowed before HALT (>=0)
- CNT_W, 8, width of fault counter
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- enable  in  1  comparison enable; 0 masks all faults
- clr_cnt  in  1  clears fault_cnt
- instr_req  in  NCORES  per-core instruction request
- instr_addr  in  NCORES*AW  per-core instruction address, core i at [i*AW +: AW]
- data_req, data_we  in  NCORES each  per-core data request / write enable
- data_be  in  NCORES*DW/8  per-core byte enables
- data_addr  in  NCORES*AW  per-core data address
- data_wdata  in  NCORES*DW  per-core write data
- core_rst_n  out  1  active-low reset to all cores
- fault_o  out  1  one-cycle fault pulse
- fault_cause  out  3  cause of last fault (cls_pkg::fault_cause_e)
- fault_core  out  NCORES  outvoted cores of last fault
- halted  out  1  retry budget exhausted
- retry_cnt  out  $clog2(MAX_RETRIES+1)  recoveries since last clean window
- fault_cnt  out  CNT_W  saturating total fault count

## Operation
- Per-core signature: {data_req, data_req?data_addr:0, data_req?data_we:0, data_req&data_we?{data_be,data_wdata}:0, instr_req, instr_req?instr_addr:0}.
- Mismatch: any core's signature differs from core 0's. Only evaluated when enable=1, state=RUN and not the blanking cycle.
- Cause, first hit in priority order: DATA_REQ, DATA_ADDR, DATA_WE, DATA_BE, DATA_WDATA, INSTR_REQ, INSTR_ADDR. NONE=0 after reset.
- fault_core[i]=1 when fewer than NCORES/2+1 cores share core i's signature.
  - If no signature has a strict majority, fault_core is all ones.
  - NCORES=2 therefore always gives 2'b11.
- States:
  - RST_HOLD: core_rst_n=0, counts RST_CYCLES, then goes to RUN.
  - RUN: core_rst_n=1.
    - Mismatch with retry_cnt<MAX_RETRIES: retry_cnt++, go to RST_HOLD.
    - Mismatch with retry_cnt==MAX_RETRIES: go to HALT.
  - HALT: core_rst_n=0 and halted=1; only rst exits.
- Clean counter: increments each RUN cycle without a mismatch and clears on any mismatch. At CLEAN_WINDOW it clears retry_cnt and restarts from 0. It does not count outside RUN.
- fault_cnt: increments on each fault_o and saturates at all ones.
  - clr_cnt clears it.
  - If clr_cnt coincides with a fault, the result is 1.

## Timing
- Reset values:
  - state=RST_HOLD with a full RST_CYCLES count; core_rst_n=0.
  - fault_o=0, fault_cause=NONE, fault_core=0, halted=0, retry_cnt=0, fault_cnt=0, clean counter=0.
- Latency: mismatch sampled at edge N gives, from N+1:
  - fault_o=1 for exactly one cycle;
  - fault_cause and fault_core updated and held until the next fault;
  - core_rst_n=0, either for RST_CYCLES cycles (recovery) or permanently (HALT).
- After RST_HOLD, the first RUN cycle is blanked (cores leaving reset). Compare resumes on the second cycle.
- Mismatch on the same cycle the clean counter reaches CLEAN_WINDOW: the fault wins. retry_cnt is not cleared, and the fault is judged against the old retry_cnt.
- enable falling mid-RST_HOLD does not shorten the pulse.
- rst asserted in any state forces the reset values immediately, regardless of clk.
- No combinational path from inputs to outputs.

## Structure
- cls_pkg holds:
  - fault_cause_e (3-bit: NONE, DATA_REQ, DATA_ADDR, DATA_WE, DATA_BE, DATA_WDATA, INSTR_REQ, INSTR_ADDR);
  - sup_state_e (RUN, RST_HOLD, HALT).
- Sub-module cls_vote_cmp: purely combinational. Builds signatures and produces mismatch, cause and fault_core.
- The top level holds the FSM, counters and output registers.

## Test plan
- NCORES=3, identical traffic for 5000 cycles with CLEAN_WINDOW=1024: fault_o never asserts, retry_cnt=0, core_rst_n=1 after the initial 2-cycle hold.
- Core 2 data_wdata differs (0xDEADBEEF vs 0xDEADBEEE) with data_we=3'b111: next edge fault_o=1, fault_cause=DATA_WDATA, fault_core=3'b100, core_rst_n low for 2 cycles, retry_cnt=1, fault_cnt=1.
- Core 1 data_req=0 while the others are 1, and its addresses also differ: fault_cause=DATA_REQ (priority), fault_core=3'b010.
- MAX_RETRIES=3, inject 4 faults within 100 cycles: the 4th gives halted=1, core_rst_n stuck at 0, and mismatches are ignored until rst.
- Faults spaced 1100 cycles apart with CLEAN_WINDOW=1024: retry_cnt returns to 0 before each, never halts.
- NCORES=4, cores 0,1 vs cores 2,3 differ on instr_addr: fault_core=4'b1111, fault_cause=INSTR_ADDR. Also check that enable=0 with mismatching traffic produces no fault.
